// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter sharing one AHB-to-APB bridge between NREQ requesters.
// Define APB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module apb_bridge_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned XFER_CYCLES = 6,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic               HCLK,
  input  logic               HRST,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [AW-1:0]      HADDR,
  output logic               Control,
  output logic [DW-1:0]      HWDATA,
  input  logic [DW-1:0]      HRDATA
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (XFER_CYCLES > 2) ? $clog2(XFER_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_winner;
  logic [CW-1:0]   r_cnt;

  logic            w_found;
  logic [IW-1:0]   w_winner;
  logic [IW-1:0]   w_idx;

  // Scan requests upward from the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = IW'((int'(r_ptr) + i) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_winner <= '0;
      r_cnt    <= '0;
      gnt      <= '0;
      done     <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      HADDR    <= '0;
      Control  <= 1'b0;
      HWDATA   <= '0;
    end else begin
      done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner <= w_winner;
            gnt      <= NREQ'(1) << w_winner;
            busy     <= 1'b1;
            HADDR    <= req_addr[w_winner*AW +: AW];
            Control  <= req_wr[w_winner];
            HWDATA   <= req_wdata[w_winner*DW +: DW];
            r_cnt    <= CW'(XFER_CYCLES - 1);
            r_state  <= S_XFER;
          end
        end
        S_XFER: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
            done    <= NREQ'(1) << r_winner;
            if (!Control) begin
              rdata <= HRDATA;
            end
`ifdef APB_ARB_FIXED_PRIO_EN
            r_ptr <= '0;
`else
            r_ptr <= IW'((int'(r_winner) + 1) % NREQ);
`endif
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          // Release the bridge; IDLE always gets at least one cycle.
          r_state <= S_IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
          HADDR   <= '0;
          Control <= 1'b0;
          HWDATA  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Randomized + directed bench for apb_bridge_arbiter against a transfer-timeline model.
module tb_apb_bridge_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned XC   = 6;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  logic               HCLK = 1'b0;
  logic               HRST;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [AW-1:0]      HADDR;
  logic               Control;
  logic [DW-1:0]      HWDATA;
  logic [DW-1:0]      HRDATA;

  apb_bridge_arbiter #(.NREQ(NREQ), .XFER_CYCLES(XC), .AW(AW), .DW(DW)) dut (
    .HCLK(HCLK), .HRST(HRST), .req(req), .req_addr(req_addr), .req_wr(req_wr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .HADDR(HADDR), .Control(Control), .HWDATA(HWDATA), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = bridge free) and edges elapsed since its grant.
  int              m_owner = -1;
  int              m_age   = 0;
  int              m_ptr   = 0;
  logic [AW-1:0]   m_addr  = '0;
  logic            m_wr    = 1'b0;
  logic [DW-1:0]   m_wdata = '0;
  logic [DW-1:0]   m_rdata = '0;
  logic [NREQ-1:0] exp_done = '0;

  task automatic model_step();
    if (HRST) begin
      m_owner = -1; m_ptr = 0; m_rdata = '0;
    end else if (m_owner < 0) begin
      int w = -1;
      for (int k = 0; k < NREQ; k++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
        int idx = k;
`else
        int idx = (m_ptr + k) % NREQ;
`endif
        if (w < 0 && req[idx]) w = idx;
      end
      if (w >= 0) begin
        m_owner = w; m_age = 0;
        m_addr  = req_addr[w*AW +: AW];
        m_wr    = req_wr[w];
        m_wdata = req_wdata[w*DW +: DW];
      end
    end else begin
      m_age++;
      if (m_age == XC) begin
        if (!m_wr) m_rdata = HRDATA;
`ifndef APB_ARB_FIXED_PRIO_EN
        m_ptr = (m_owner + 1) % NREQ;
`endif
      end else if (m_age == XC + 1) begin
        m_owner = -1;
      end
    end
  endtask

  int cyc = 0;
  int zero_run = 0;
  logic [NREQ-1:0] prev_gnt = '0;
  int grants[$];
  int gaps[$];

  task automatic tick();
    logic [NREQ-1:0] eg;
    model_step();
    @(posedge HCLK);
    #1;
    cyc++;
    eg       = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
    exp_done = (m_owner >= 0 && m_age == XC) ? eg : '0;
    check("gnt", gnt, eg);
    check("done", done, exp_done);
    check("busy", busy, m_owner >= 0);
    check("rdata", rdata, m_rdata);
    check("HADDR", HADDR, (m_owner >= 0) ? m_addr : '0);
    check("Control", Control, (m_owner >= 0) ? m_wr : 1'b0);
    check("HWDATA", HWDATA, (m_owner >= 0) ? m_wdata : '0);
    check("gnt_onehot", $countones(gnt) <= 1, 1'b1);
    if (gnt == '0) zero_run++;
    else if (prev_gnt == '0) begin
      for (int k = 0; k < NREQ; k++) if (gnt[k]) grants.push_back(k);
      gaps.push_back(zero_run);
      zero_run = 0;
    end
    prev_gnt = gnt;
  endtask

  task automatic serve(input int i);
    int t0 = -1;
    int t1 = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (gnt[i] && t0 < 0) t0 = cyc;
      if (done[i]) begin t1 = cyc; break; end
    end
    check($sformatf("done%0d_seen", i), done[i], 1'b1);
    check($sformatf("latency%0d", i), 64'(t1 - t0), 64'(XC));
  endtask

  task automatic do_reset();
    HRST = 1'b1; req = '0;
    tick();
    HRST = 1'b0;
    grants.delete(); gaps.delete();
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (!req[i]) begin
        req_addr[i*AW +: AW]  = $urandom;
        req_wdata[i*DW +: DW] = $urandom;
        req_wr[i]             = 1'($urandom_range(0, 1));
        req[i]                = ($urandom_range(0, 3) == 0);
      end else if (exp_done[i]) begin
        req[i] = ($urandom_range(0, 1) == 0);
      end else if (m_owner == i) begin
        // Owner-side changes mid-transfer must be ignored by the bridge.
        req_addr[i*AW +: AW]  = $urandom;
        req_wdata[i*DW +: DW] = $urandom;
        req_wr[i]             = ~req_wr[i];
        if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
    end
    HRDATA = $urandom;
    HRST   = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    HRST = 1'b1; req = '0; req_addr = '0; req_wr = '0; req_wdata = '0; HRDATA = '0;
    repeat (2) tick();
    HRST = 1'b0;

    // Single write
    req_addr[0 +: AW] = 32'h0000000C; req_wr[0] = 1'b1; req_wdata[0 +: DW] = 32'hAAAAAAAA;
    req[0] = 1'b1;
    serve(0);
    req[0] = 1'b0;
    repeat (2) tick();

    // Single read
    req_addr[AW +: AW] = 32'h0000010C; req_wr[1] = 1'b0; HRDATA = 32'hBBBBBBBB;
    req[1] = 1'b1;
    serve(1);
    check("read_rdata", rdata, 32'hBBBBBBBB);
    req[1] = 1'b0; HRDATA = 32'h12345678;
    repeat (3) tick();
    check("rdata_held", rdata, 32'hBBBBBBBB);

`ifndef APB_ARB_FIXED_PRIO_EN
    // Round-robin contention
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 100 && grants.size() < 5; k++) tick();
    check("rr_count", grants.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_order%0d", k), (k < grants.size()) ? grants[k] : -1, exp_rr[k]);
      if (k > 0) check($sformatf("rr_gap%0d", k), (k < gaps.size()) ? gaps[k] : -1, 1);
    end

    // Pointer wrap after serving requester 3
    do_reset();
    req = 4'b1000;
    serve(3);
    req = 4'b1001;
    grants.delete();
    for (int k = 0; k < 40 && grants.size() < 2; k++) tick();
    check("wrap_first", (grants.size() > 0) ? grants[0] : -1, 0);
    check("wrap_second", (grants.size() > 1) ? grants[1] : -1, 3);
    req = '0;
    repeat (16) tick();
`else
    // Fixed priority: requester 1 always beats 3
    do_reset();
    req = 4'b1010;
    for (int k = 0; k < 100 && grants.size() < 4; k++) tick();
    check("fp_count", grants.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("fp_grant%0d", k), (k < grants.size()) ? grants[k] : -1, 1);
`endif

    // Reset mid-transfer
    do_reset();
    req_addr[3*AW +: AW] = 32'h0000030C; req_wr[3] = 1'b1; req_wdata[3*DW +: DW] = 32'h5A5A5A5A;
    req = 4'b1000;
    for (int k = 0; k < 10 && !gnt[3]; k++) tick();
    check("mid_granted", gnt[3], 1'b1);
    repeat (2) tick();
    HRST = 1'b1;
    tick();
    check("mid_gnt", gnt, '0);
    check("mid_busy", busy, 1'b0);
    check("mid_haddr", HADDR, '0);
    check("mid_done", done, '0);
    HRST = 1'b0;
    req = 4'b1100;
    grants.delete();
    for (int k = 0; k < 10 && grants.size() < 1; k++) tick();
    check("post_reset_first", (grants.size() > 0) ? grants[0] : -1, 2);

    // Randomized traffic
    req = '0;
    for (int k = 0; k < 1500; k++) begin
      rand_inputs();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
